// File: rtl/ring_counter_gen.sv
// ring_counter_gen: parametrised ring/Johnson counter with load, direction, self-correction and wrap pulse
module ring_counter_gen #(
    parameter int WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);
    logic [WIDTH-1:0] s, nq, step;
    logic ring_ok, john_ok, legal;
    always_comb begin
        nq      = ~q;
        s       = mode ? '0 : WIDTH'(1);
        ring_ok = (q != '0) && ((q & (q - WIDTH'(1))) == '0);
        // Johnson legal: ones (or zeros) packed contiguously from the LSB
        john_ok = ((q & (q + WIDTH'(1))) == '0) || ((nq & (nq + WIDTH'(1))) == '0);
        legal   = mode ? john_ok : ring_ok;
        step    = dir ? {q[0] ^ mode, q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1] ^ mode};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= INIT;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else if (load) begin
            q    <= load_val;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else if (en) begin
            q    <= legal ? step : s;
            wrap <= legal && (step == s);
            err  <= !legal;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ring_counter_gen.sv
// tb_ring_counter_gen: directed self-checking bench for ring_counter_gen (WIDTH 4, INIT 0001)
module tb_ring_counter_gen;
    logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'b0000;
    logic [3:0] q;
    logic wrap, err;
    int n_tests = 0, n_fail = 0;
    logic [3:0] ring_up [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] john_up [8]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [3:0] john_dn [8]  = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};

    ring_counter_gen #(.WIDTH(4), .INIT(4'b0001)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_val(load_val), .q(q), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] eq, input logic ew, input logic ee);
        check({tag, ".q"}, {28'd0, q}, {28'd0, eq});
        check({tag, ".wrap"}, {31'd0, wrap}, {31'd0, ew});
        check({tag, ".err"}, {31'd0, err}, {31'd0, ee});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1; load_val = v; en = 1'b0;
        tick();
        load = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_state("reset", 4'b0001, 1'b0, 1'b0);
        #5 rst_n = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_state($sformatf("ring_up%0d", i), ring_up[i], i == 3, 1'b0);
        end
        mode = 1'b1;
        do_load(4'b0000);
        chk_state("load0", 4'b0000, 1'b0, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_state($sformatf("john_up%0d", i), john_up[i], i == 7, 1'b0);
        end
        dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_state($sformatf("john_dn%0d", i), john_dn[i], i == 7, 1'b0);
        end
        mode = 1'b0; dir = 1'b0;
        do_load(4'b0001);
        en = 1'b1;
        tick();
        chk_state("rev_up", 4'b0010, 1'b0, 1'b0);
        dir = 1'b1;
        tick();
        chk_state("rev_dn", 4'b0001, 1'b1, 1'b0);
        dir = 1'b0;
        do_load(4'b0110);
        chk_state("ring_bad_load", 4'b0110, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        chk_state("ring_fix", 4'b0001, 1'b0, 1'b1);
        mode = 1'b1;
        do_load(4'b0101);
        en = 1'b1;
        tick();
        chk_state("john_fix", 4'b0000, 1'b0, 1'b1);
        do_load(4'b0011);
        mode = 1'b0; en = 1'b1;
        tick();
        chk_state("mode_switch_fix", 4'b0001, 1'b0, 1'b1);
        en = 1'b1; load = 1'b1; load_val = 4'b0100;
        tick();
        load = 1'b0;
        chk_state("load_over_en", 4'b0100, 1'b0, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_state($sformatf("hold%0d", i), 4'b0100, 1'b0, 1'b0);
        end
        mode = 1'b1;
        do_load(4'b1000);
        en = 1'b1;
        tick();
        chk_state("pre_rst_wrap", 4'b0000, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_state("async_rst_wrap", 4'b0001, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        do_load(4'b0101);
        en = 1'b1;
        tick();
        chk_state("pre_rst_err", 4'b0000, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_state("async_rst_err", 4'b0001, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        mode = 1'b0; dir = 1'b0; en = 1'b1;
        tick();
        chk_state("post_rst_step", 4'b0010, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/ring_counter_gen.md
# ring_counter_gen

Parametrised ring/Johnson counter, the next generation of the team's fixed 4-bit ring counter. It adds run-time mode selection (one-hot ring or twisted-ring Johnson), direction control, count enable, parallel load, illegal-state self-correction, and a wrap pulse. It is intended for phase/strobe generation and sequencing in datapath and control blocks.

## Interface
- WIDTH, 4: counter width in bits; legal range is 2 to 32.
- INIT, 1: reset value of q, WIDTH bits wide. It should be legal for the mode used after reset.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  step enable
- dir  in  1  0 = up (shift toward MSB), 1 = down (shift toward LSB)
- mode  in  1  0 = ring (one-hot), 1 = Johnson
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value loaded when load = 1
- q  out  WIDTH  counter state, registered
- wrap  out  1  registered one-cycle pulse: the counter stepped into the start pattern
- err  out  1  registered one-cycle pulse: an illegal state was corrected

## Operation
- Reset: one clock and asynchronous active-low reset.
  - rst_n = 0 forces q = INIT, wrap = 0 and err = 0 immediately, independent of clk.
- Start pattern S:
  - Ring mode: S = 1 (bit 0 only).
  - Johnson mode: S = 0 (all zeros).
- Legal states:
  - Ring: exactly one bit set (WIDTH states).
  - Johnson: q = 2^k − 1 or ~q = 2^k − 1, for k = 0..WIDTH (2·WIDTH states).
- Priority on each rising edge: reset > load > en > hold.
- load = 1:
  - q ← load_val, verbatim, with no legality check at load time.
  - wrap ← 0, err ← 0.
  - en is ignored.
- en = 1, load = 0, q illegal for the current mode:
  - q ← S, err ← 1, wrap ← 0.
- en = 1, load = 0, q legal:
  - Ring, up: q ← {q[WIDTH-2:0], q[WIDTH-1]} (rotate left).
  - Ring, down: q ← {q[0], q[WIDTH-1:1]} (rotate right).
  - Johnson, up: q ← {q[WIDTH-2:0], ~q[WIDTH-1]}.
  - Johnson, down: q ← {~q[0], q[WIDTH-1:1]}.
  - wrap ← 1 if the next q equals S, else 0. err ← 0.
- en = 0, load = 0: q holds; wrap ← 0, err ← 0.
- Mode and direction changes:
  - mode is evaluated combinationally each cycle and is not latched.
  - Switching mode while q is illegal for the new mode is corrected at the next enabled step, with err pulsing.
  - Switching mode does not alter q by itself.
  - dir may change on any cycle; the next step uses the new direction with no extra latency.
- Period with en held high:
  - Ring: WIDTH cycles between wrap pulses.
  - Johnson: 2·WIDTH cycles between wrap pulses.
- wrap and err are mutually exclusive in any cycle.

## Timing
- Latency: one clock from the en/load edge to updated q. wrap and err are registered and valid in the same cycle as the new q they describe.
- wrap and err each last exactly one cycle per event. They re-assert on consecutive cycles only when the conditions recur; for example, WIDTH = 2 ring up with en held toggles q and pulses wrap every second cycle.
- Reset mid-operation: deassertion is synchronous to the design's usage. The first edge after rst_n rises performs a normal step from INIT if en = 1.
- No combinational path from any input to any output.

## Test plan
- Reset, then en = 1, mode = 0, dir = 0, WIDTH = 4, INIT = 0001:
  - q: 0001 → 0010 → 0100 → 1000 → 0001.
  - wrap = 1 only in the cycle q returns to 0001.
- mode = 1, dir = 0, from q = 0000:
  - q: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
  - wrap pulses at 0000 after 8 steps.
- mode = 1, dir = 1 from 0000:
  - q: 1000, 1100, 1110, 1111, 0111, …, returning to 0000.
- Ring mode, direction reversal mid-sequence:
  - Step 0001 → 0010, then set dir = 1: q → 0001 with wrap = 1.
- Self-correction:
  - Ring mode: load_val = 0110, then en = 1 gives q = 0001, err = 1, wrap = 0.
  - Johnson mode: load 0101, step gives q = 0000, err = 1.
- Priority and reset:
  - load = 1 and en = 1 together with load_val = 0100: q = 0100, no step, no pulses.
  - en = 0: q holds for 5 cycles.
  - Asserting rst_n = 0 between clock edges sets q = 0001 asynchronously and clears wrap and err.
